// File: rtl/mul_pkg.sv
// Shared definitions for the sequential schoolbook multiplier.
// Contents: FSM state enum, a constant-friendly clog2, and the width
// derivations used to size the accumulator and the digit index counters.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input longint value);
        int res;
        res = 0;
        while ((longint'(1) << res) < value) begin
            res = res + 1;
        end
        return res;
    endfunction

    // Accumulator width: worst-case column sum of DIGITS digit products
    // plus the carry coming in from the previous column, with one bit of margin.
    function automatic int acc_width(input int digits, input int radix);
        longint worst;
        worst = longint'(digits) * longint'(radix - 1) * longint'(radix - 1)
              + longint'(digits) * longint'(radix);
        return clog2(worst) + 1;
    endfunction

    // Index width that never collapses to zero bits (DIGITS = 1 case).
    function automatic int idx_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/radix_divmod.sv
// Combinational split of a column total into (t mod RADIX, t div RADIX).
// Ports:
//   t_i    column total (accumulator + current digit product)
//   rem_o  t mod RADIX, the result digit for the column
//   quo_o  t div RADIX, the carry into the next column
module radix_divmod
    import mul_pkg::*;
#(
    parameter int RADIX = 10,
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0] t_i,
    output logic [ACC_W-1:0] rem_o,
    output logic [ACC_W-1:0] quo_o
);

    localparam logic [ACC_W-1:0] RADIX_W = ACC_W'(RADIX);

    generate
        if ((RADIX & (RADIX - 1)) == 0) begin : g_pow2
            // Power-of-two radix: division is a plain shift and mask.
            localparam int SH = clog2(RADIX);
            assign rem_o = t_i & (RADIX_W - ACC_W'(1));
            assign quo_o = t_i >> SH;
        end else begin : g_generic
            assign rem_o = t_i % RADIX_W;
            assign quo_o = t_i / RADIX_W;
        end
    endgenerate

endmodule

// File: rtl/mul_seq.sv
// Sequential N-digit x N-digit multiplier in an arbitrary radix.
// Walks the product column by column; each column takes DIGITS cycles of
// multiply-accumulate, then its digit is split off and the remainder carried.
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   operand handshake; in_ready only while idle
//   x, y                  operands, DIGITS digits of DW bits, digit 0 at LSBs
//   out_valid / out_ready result handshake; result held until taken
//   z                     2*DIGITS-digit product, same packing as operands
//   err                   an operand digit was >= RADIX (z forced to 0)
module mul_seq
    import mul_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int RADIX  = 10,
    parameter int DW     = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DIGITS*DW-1:0]   x,
    input  logic [DIGITS*DW-1:0]   y,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*DIGITS*DW-1:0] z,
    output logic                   err
);

    localparam int ACC_W = acc_width(DIGITS, RADIX);
    localparam int IW    = idx_width(DIGITS);
    localparam int KW    = clog2(2 * DIGITS);

    state_e state_q, state_d;

    logic [DIGITS*DW-1:0]   x_q, x_d;
    logic [DIGITS*DW-1:0]   y_q, y_d;
    logic [2*DIGITS*DW-1:0] z_q, z_d;
    logic                   err_q, err_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [IW-1:0]          i_q, i_d;
    logic [KW-1:0]          k_q, k_d;

    // Operand digit views and range check on the incoming operands.
    logic [DW-1:0]     x_dig [DIGITS];
    logic [DW-1:0]     y_dig [DIGITS];
    logic [DIGITS-1:0] bad_x, bad_y;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_dig
            assign x_dig[gi] = x_q[gi*DW +: DW];
            assign y_dig[gi] = y_q[gi*DW +: DW];
            assign bad_x[gi] = (32'(x[gi*DW +: DW]) >= 32'(RADIX));
            assign bad_y[gi] = (32'(y[gi*DW +: DW]) >= 32'(RADIX));
        end
    endgenerate

    logic operand_bad;
    logic accept;
    logic last_i, last_col, last_step;

    assign operand_bad = (|bad_x) | (|bad_y);
    assign accept      = in_valid & in_ready;
    assign last_i      = (i_q == IW'(DIGITS - 1));
    assign last_col    = (k_q == KW'(2 * DIGITS - 1));
    assign last_step   = last_i & last_col;

    // Current term x[i] * y[k-i]; zero when k-i falls outside the operand.
    logic [KW-1:0]    j_idx;
    logic             in_range;
    logic [DW-1:0]    y_sel;
    logic [ACC_W-1:0] term;
    logic [ACC_W-1:0] t_sum;
    logic [ACC_W-1:0] col_rem;
    logic [ACC_W-1:0] col_quo;

    assign j_idx    = k_q - KW'(i_q);
    assign in_range = (k_q >= KW'(i_q)) && (j_idx < KW'(DIGITS));
    assign y_sel    = y_dig[j_idx[IW-1:0]];
    assign term     = in_range ? (ACC_W'(x_dig[i_q]) * ACC_W'(y_sel)) : '0;
    assign t_sum    = acc_q + term;

    radix_divmod #(
        .RADIX (RADIX),
        .ACC_W (ACC_W)
    ) u_divmod (
        .t_i   (t_sum),
        .rem_o (col_rem),
        .quo_o (col_quo)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)    state_d = operand_bad ? DONE : CALC;
            CALC: if (last_step) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    // Datapath next state
    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        z_d   = z_q;
        err_d = err_q;
        acc_d = acc_q;
        i_d   = i_q;
        k_d   = k_q;
        if (state_q == IDLE && accept) begin
            x_d   = x;
            y_d   = y;
            z_d   = '0;
            err_d = operand_bad;
            acc_d = '0;
            i_d   = '0;
            k_d   = '0;
        end else if (state_q == CALC) begin
            if (last_i) begin
                // Column complete: emit its digit, carry the rest onward.
                z_d[k_q*DW +: DW] = DW'(col_rem);
                acc_d             = col_quo;
                i_d               = '0;
                k_d               = last_col ? '0 : k_q + KW'(1);
            end else begin
                acc_d = t_sum;
                i_d   = i_q + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            z_q   <= '0;
            err_q <= 1'b0;
            acc_q <= '0;
            i_q   <= '0;
            k_q   <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            z_q   <= z_d;
            err_q <= err_d;
            acc_q <= acc_d;
            i_q   <= i_d;
            k_q   <= k_d;
        end
    end

    assign z   = z_q;
    assign err = err_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: decimal 4-digit instance driven from a
// vector table plus back-pressure and reset-abort sequences, and a
// hexadecimal 2-digit instance for the power-of-two radix path.
module tb_mul_seq;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, err;
    logic [15:0] x, y;
    logic [31:0] z;

    logic        in_valid2, in_ready2, out_valid2, out_ready2, err2;
    logic [7:0]  x2, y2;
    logic [15:0] z2;

    int passed = 0;
    int total  = 0;

    mul_seq #(.DIGITS(4), .RADIX(10), .DW(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z         (z),
        .err       (err)
    );

    mul_seq #(.DIGITS(2), .RADIX(16), .DW(4)) dut_hex (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .x         (x2),
        .y         (y2),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .z         (z2),
        .err       (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // Present operands, wait for the accept edge, then count edges until
    // out_valid is seen. lat = 0 means valid right after the accepting edge.
    task automatic do_op(input logic [15:0] xv, input logic [15:0] yv,
                         output logic [31:0] zr, output logic er, output int lat);
        int w;
        @(negedge clk);
        x = xv;
        y = yv;
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        zr = z;
        er = err;
    endtask

    typedef struct {
        logic [15:0] xv;
        logic [15:0] yv;
        logic [31:0] zv;
        logic        ev;
        int          lat;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [31:0] zr;
        logic        er;
        int          lat;
        logic [31:0] z_hold;

        vecs[0] = '{16'h1234, 16'h5678, 32'h07006652, 1'b0, 32};
        vecs[1] = '{16'h9999, 16'h9999, 32'h99980001, 1'b0, 32};
        vecs[2] = '{16'h0000, 16'h9999, 32'h00000000, 1'b0, 32};
        vecs[3] = '{16'h00A0, 16'h0001, 32'h00000000, 1'b1, 0};
        vecs[4] = '{16'h0001, 16'h0001, 32'h00000001, 1'b0, 32};
        vecs[5] = '{16'h1000, 16'h1000, 32'h01000000, 1'b0, 32};
        vecs[6] = '{16'h0009, 16'h0009, 32'h00000081, 1'b0, 32};
        vecs[7] = '{16'h0005, 16'h000F, 32'h00000000, 1'b1, 0};
        vecs[8] = '{16'h4321, 16'h0007, 32'h00030247, 1'b0, 32};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        x          = '0;
        y          = '0;
        in_valid2  = 1'b0;
        out_ready2 = 1'b1;
        x2         = '0;
        y2         = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset z", z, 0);
        check("reset err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int v = 0; v < 9; v++) begin
            do_op(vecs[v].xv, vecs[v].yv, zr, er, lat);
            $display("op %0d: x=%h y=%h -> z=%h err=%0d lat=%0d", v, vecs[v].xv, vecs[v].yv, zr, er, lat);
            check($sformatf("vec%0d z", v), zr, vecs[v].zv);
            check($sformatf("vec%0d err", v), er, vecs[v].ev);
            check($sformatf("vec%0d latency", v), lat, vecs[v].lat);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid one cycle", v), out_valid, 0);
        end

        // Back-pressure: result held while out_ready is low, no re-accept
        out_ready = 1'b0;
        do_op(16'h1234, 16'h5678, zr, er, lat);
        $display("bp op: x=1234 y=5678 -> z=%h err=%0d lat=%0d", zr, er, lat);
        check("bp z", zr, 32'h07006652);
        z_hold = zr;
        @(negedge clk);
        x = 16'h9999;
        y = 16'h9999;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("bp hold %0d", c), {out_valid, in_ready, z}, {1'b1, 1'b0, z_hold});
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release out_valid", out_valid, 0);
        check("bp release in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp new accept", in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("bp op2: x=9999 y=9999 -> z=%h lat=%0d", z, lat);
        check("bp op2 latency", lat, 32);
        check("bp op2 z", z, 32'h99980001);
        @(posedge clk);
        #1;

        // Reset aborting an operation mid-CALC
        @(negedge clk);
        x = 16'h1234;
        y = 16'h5678;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        // Columns 0..2 are written after 12 MAC cycles; 1234*5678 ends in ...652.
        check("mid calc partial z", z, 32'h00000652);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort out_valid", out_valid, 0);
        check("abort z", z, 0);
        check("abort err", err, 0);
        check("abort in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(16'h0012, 16'h0012, zr, er, lat);
        $display("post-reset op: x=0012 y=0012 -> z=%h err=%0d lat=%0d", zr, er, lat);
        check("post reset z", zr, 32'h00000144);
        check("post reset latency", lat, 32);
        @(posedge clk);
        #1;

        // Hexadecimal 2-digit instance
        @(negedge clk);
        x2 = 8'hFF;
        y2 = 8'hFF;
        in_valid2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        $display("hex op: x=FF y=FF -> z=%h err=%0d lat=%0d", z2, err2, lat);
        check("hex z", z2, 16'hFE01);
        check("hex err", err2, 0);
        check("hex latency", lat, 8);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
